// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, master state encoding and default widths.
package spi_pkg;

  localparam int unsigned FRAME_W_DFLT = 10;
  localparam int unsigned DATA_W_DFLT  = 8;
  localparam int unsigned CMD_W        = 2;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake between a system-side caller and spi_master.
interface spi_master_if #(
  parameter int unsigned DATA_W = spi_pkg::DATA_W_DFLT
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd;
  logic [DATA_W-1:0] cmd_payload;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  // Caller side issues requests and consumes responses
  modport master (
    output cmd_valid, cmd, cmd_payload,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  // spi_master side
  modport slave (
    input  cmd_valid, cmd, cmd_payload,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register with serial input.
module spi_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] load_val,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[W-2:0], ser_in};
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serialises {cmd, payload} frames on MOSI and captures read-data bytes from MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DFLT,
  parameter int unsigned DATA_W  = DATA_W_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  bus,
  output logic         SS_n,
  output logic         MOSI,
  input  logic         MISO
);

  localparam int unsigned CNT_W = $clog2(FRAME_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               ss_n_d, busy_d, ready_d, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_d;
  logic               frame_load, frame_shift, rx_shift;
  logic [FRAME_W-1:0] frame_q;
  logic [DATA_W-1:0]  rx_q;
  logic               unused_bits;

  // Frame serialiser: zeros shift in behind the frame, so MOSI idles low once it drains
  spi_shift_reg #(.W(FRAME_W)) u_tx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_load),
    .shift_en (frame_shift),
    .load_val ({bus.cmd, bus.cmd_payload}),
    .ser_in   (1'b0),
    .q        (frame_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .shift_en (rx_shift),
    .load_val ('0),
    .ser_in   (MISO),
    .q        (rx_q)
  );

  assign MOSI        = frame_q[FRAME_W-1];
  assign unused_bits = ^{frame_q[FRAME_W-2:0], rx_q[DATA_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_q          <= 1'b0;
      SS_n          <= 1'b1;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      SS_n          <= ss_n_d;
      bus.cmd_ready <= ready_d;
      bus.busy      <= busy_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_data  <= rsp_data_d;
    end
  end

  // Next state; registered outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    frame_load  = 1'b0;
    frame_shift = 1'b0;
    rx_shift    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = bus.rsp_data;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          frame_load = 1'b1;
          rd_d       = (bus.cmd == CMD_RD_DATA);
          state_d    = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = CNT_W'(FRAME_W - 1);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        frame_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = rd_q ? ST_TURN : ST_STOP;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      ST_TURN: begin
        cnt_d   = CNT_W'(DATA_W - 1);
        state_d = ST_RECV;
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[DATA_W-2:0], MISO};
          state_d     = ST_STOP;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ss_n_d  = (state_d == ST_IDLE) || (state_d == ST_STOP);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

endmodule
